// File: rtl/alu_mult_sequencer_if.sv
// Bundles the multiply request/response handshake and the shared-ALU drive/return lines.
interface alu_mult_sequencer_if;
   logic        start;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic        busy;
   logic        done;
   logic [31:0] product;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_control;
   logic [4:0]  alu_shamt;
   logic [31:0] alu_result;

   modport master (
      output start, multiplicand, multiplier, alu_result,
      input  busy, done, product, alu_a, alu_b, alu_control, alu_shamt
   );

   modport slave (
      input  start, multiplicand, multiplier, alu_result,
      output busy, done, product, alu_a, alu_b, alu_control, alu_shamt
   );
endinterface

// File: rtl/alu_mult_sequencer.sv
// Shift-and-add multiplier with no adder of its own: alternates ADD and SLL-by-1
// on the shared ALU, one pair per multiplier bit, and pulses done with the product.
module alu_mult_sequencer (
   input logic                 clk,
   input logic                 reset,
   alu_mult_sequencer_if.slave bus
);
   localparam int unsigned DW  = 32;
   localparam int unsigned SW  = 5;
   localparam int unsigned OPW = 4;

   localparam logic [OPW-1:0] OP_ADD = 4'b0010;
   localparam logic [OPW-1:0] OP_SLL = 4'b1000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ADD   = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t         state, state_nxt;
   logic [DW-1:0]  acc, acc_nxt;
   logic [DW-1:0]  mcand, mcand_nxt;
   logic [DW-1:0]  mplier, mplier_nxt;

   logic           busy_r, done_r;
   logic [DW-1:0]  alu_a_r, alu_a_nxt;
   logic [DW-1:0]  alu_b_r, alu_b_nxt;
   logic [OPW-1:0] alu_ctl_r, alu_ctl_nxt;
   logic [SW-1:0]  alu_shamt_r, alu_shamt_nxt;

   // Next-state and datapath updates; arithmetic comes back through alu_result.
   always_comb begin
      state_nxt  = state;
      acc_nxt    = acc;
      mcand_nxt  = mcand;
      mplier_nxt = mplier;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               acc_nxt    = '0;
               mcand_nxt  = bus.multiplicand;
               mplier_nxt = bus.multiplier;
               state_nxt  = S_ADD;
            end
         end
         S_ADD: begin
            if (mplier == '0) begin
               state_nxt = S_DONE;
            end else begin
               acc_nxt   = bus.alu_result;
               state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            mcand_nxt  = bus.alu_result;
            mplier_nxt = mplier >> 1;
            state_nxt  = S_ADD;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ALU drive for the upcoming cycle, derived from next-state values so it can be registered.
   always_comb begin
      alu_a_nxt     = acc_nxt;
      alu_b_nxt     = '0;
      alu_ctl_nxt   = OP_ADD;
      alu_shamt_nxt = '0;
      case (state_nxt)
         S_ADD: begin
            alu_b_nxt = mplier_nxt[0] ? mcand_nxt : '0;
         end
         S_SHIFT: begin
            alu_a_nxt     = mcand_nxt;
            alu_ctl_nxt   = OP_SLL;
            alu_shamt_nxt = SW'(1);
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         acc         <= '0;
         mcand       <= '0;
         mplier      <= '0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         alu_a_r     <= '0;
         alu_b_r     <= '0;
         alu_ctl_r   <= OP_ADD;
         alu_shamt_r <= '0;
      end else begin
         state       <= state_nxt;
         acc         <= acc_nxt;
         mcand       <= mcand_nxt;
         mplier      <= mplier_nxt;
         busy_r      <= (state_nxt == S_ADD) || (state_nxt == S_SHIFT);
         done_r      <= (state_nxt == S_DONE);
         alu_a_r     <= alu_a_nxt;
         alu_b_r     <= alu_b_nxt;
         alu_ctl_r   <= alu_ctl_nxt;
         alu_shamt_r <= alu_shamt_nxt;
      end
   end

   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.product     = acc;
   assign bus.alu_a       = alu_a_r;
   assign bus.alu_b       = alu_b_r;
   assign bus.alu_control = alu_ctl_r;
   assign bus.alu_shamt   = alu_shamt_r;
endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Bench for alu_mult_sequencer: behavioural ALU, directed corner cases and a random sweep
// checked cycle by cycle against an arithmetic model of the shift-and-add schedule.
module tb_alu_mult_sequencer;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b1000;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   alu_mult_sequencer_if bus ();

   alu_mult_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared combinational ALU model.
   always_comb begin
      case (bus.alu_control)
         OP_ADD:  bus.alu_result = bus.alu_a + bus.alu_b;
         OP_SLL:  bus.alu_result = bus.alu_a << bus.alu_shamt;
         default: bus.alu_result = 32'd0;
      endcase
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, got hang, required completion");
      $fatal(1, "watchdog");
   end

   function automatic int calc_n(input logic [31:0] b);
      for (int i = 31; i >= 0; i--)
         if (b[i]) return i + 1;
      return 0;
   endfunction

   // Issue one multiply and check every cycle up to and including done.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit hold);
      bit          accepted;
      int          nb, dc, k;
      logic [63:0] mask;
      logic [74:0] obs, expv;
      logic [31:0] exp_a, exp_b, prod;
      logic [3:0]  exp_ctl;
      logic [4:0]  exp_sh;
      bus.multiplicand = a;
      bus.multiplier   = b;
      bus.start        = 1'b1;
      accepted = 1'b0;
      for (int w = 0; w < 4; w++) begin
         @(posedge clk);
         #1;
         if (bus.busy) begin
            accepted = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!accepted) begin
         n_err++;
         $display("FAIL accept: busy never rose for %h*%h, required busy=1 within 4 cycles", a, b);
         bus.start = 1'b0;
         return;
      end
      if (!hold) bus.start = 1'b0;
      nb   = calc_n(b);
      dc   = 2 * nb + 2;
      prod = a * b;
      for (int cyc = 1; cyc <= dc; cyc++) begin
         @(negedge clk);
         if (hold && cyc == 2) begin
            bus.multiplicand = $urandom;
            bus.multiplier   = $urandom;
         end
         k = (cyc - 1) / 2;
         if (cyc == dc) begin
            exp_ctl = OP_ADD; exp_sh = 5'd0; exp_a = prod; exp_b = 32'd0;
         end else if (cyc % 2 == 1) begin
            mask    = (64'd1 << k) - 64'd1;
            exp_ctl = OP_ADD;
            exp_sh  = 5'd0;
            exp_a   = a * 32'(64'(b) & mask);
            exp_b   = (k < 32 && b[k]) ? (a << k) : 32'd0;
         end else begin
            exp_ctl = OP_SLL; exp_sh = 5'd1; exp_a = a << k; exp_b = 32'd0;
         end
         expv = {(cyc <= 2 * nb + 1), (cyc == dc), exp_ctl, exp_sh, exp_a, exp_b};
         obs  = {bus.busy, bus.done, bus.alu_control, bus.alu_shamt, bus.alu_a, bus.alu_b};
         n_cmp++;
         if (obs !== expv) begin
            n_err++;
            $display("FAIL cycle %0d of %h*%h: got busy/done/ctl/sh/a/b=%b/%b/%h/%0d/%h/%h, required %b/%b/%h/%0d/%h/%h",
                     cyc, a, b, obs[74], obs[73], obs[72:69], obs[68:64], obs[63:32], obs[31:0],
                     expv[74], expv[73], expv[72:69], expv[68:64], expv[63:32], expv[31:0]);
         end
      end
      n_cmp++;
      if (bus.product !== prod) begin
         n_err++;
         $display("FAIL product %h*%h: got %h, required %h", a, b, bus.product, prod);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.start = 1'b0;
      bus.multiplicand = 32'd0;
      bus.multiplier = 32'd0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({bus.busy, bus.done, bus.product, bus.alu_control, bus.alu_a, bus.alu_b, bus.alu_shamt}
          !== {1'b0, 1'b0, 32'd0, OP_ADD, 32'd0, 32'd0, 5'd0}) begin
         n_err++;
         $display("FAIL reset_state: got busy=%b done=%b product=%h ctl=%h a=%h b=%h sh=%0d, required 0/0/0/2/0/0/0",
                  bus.busy, bus.done, bus.product, bus.alu_control, bus.alu_a, bus.alu_b, bus.alu_shamt);
      end
      reset = 1'b0;
   endtask

   task automatic test_directed();
      run_op(32'd6, 32'd7, 1'b0);
      run_op(32'h1234, 32'd0, 1'b0);
      run_op(32'd0, 32'h1234, 1'b0);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op(32'h8000_0000, 32'd2, 1'b0);
   endtask

   task automatic test_start_held();
      bit fin;
      run_op(32'd3, 32'd5, 1'b1);
      @(negedge clk);
      n_cmp++;
      if ({bus.busy, bus.done, bus.product} !== {1'b0, 1'b0, 32'd15}) begin
         n_err++;
         $display("FAIL held_idle: got busy=%b done=%b product=%h, required 0/0/0000000f",
                  bus.busy, bus.done, bus.product);
      end
      @(negedge clk);
      n_cmp++;
      if ({bus.busy, bus.product} !== {1'b1, 32'd0}) begin
         n_err++;
         $display("FAIL held_restart: got busy=%b product=%h, required 1/00000000", bus.busy, bus.product);
      end
      bus.start = 1'b0;
      fin = 1'b0;
      for (int w = 0; w < 70; w++) begin
         @(negedge clk);
         if (bus.done) begin
            fin = 1'b1;
            break;
         end
      end
      n_cmp++;
      if (!fin) begin
         n_err++;
         $display("FAIL held_drain: got no done within 70 cycles, required done");
      end
   endtask

   task automatic test_reset_mid_op();
      bus.multiplicand = 32'd100;
      bus.multiplier   = 32'd200;
      bus.start        = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({bus.busy, bus.done, bus.product} !== {1'b0, 1'b0, 32'd0}) begin
         n_err++;
         $display("FAIL reset_mid_op: got busy=%b done=%b product=%h, required 0/0/00000000",
                  bus.busy, bus.done, bus.product);
      end
      reset = 1'b0;
      run_op(32'd9, 32'd9, 1'b0);
      // reset and start together: reset wins and the request is dropped.
      @(negedge clk);
      reset = 1'b1;
      bus.start = 1'b1;
      bus.multiplicand = 32'd4;
      bus.multiplier = 32'd4;
      @(negedge clk);
      reset = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({bus.busy, bus.product} !== {1'b0, 32'd0}) begin
         n_err++;
         $display("FAIL reset_with_start: got busy=%b product=%h, required 0/00000000", bus.busy, bus.product);
      end
   endtask

   task automatic test_random_sweep();
      logic [31:0] a, b;
      for (int i = 0; i < 1000; i++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         run_op(a, b, 1'b0);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      test_reset();
      test_directed();
      test_start_held();
      test_reset_mid_op();
      test_random_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
